// File: rtl/munoc_slave_req_dispatcher.sv
`default_nettype none
// ============================================================================
// munoc_slave_req_dispatcher : NoC slave request to AXI4 AR/AW/W dispatcher
// Revision : 1.0
// ============================================================================
module munoc_slave_req_dispatcher #(
  parameter int NODE_ID         = 0,
  parameter int NODE_WIDTH      = 4,
  parameter int TID_WIDTH       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int ID_MODE         = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [NODE_WIDTH-1:0]   req_dst_node,
  input  logic [NODE_WIDTH-1:0]   req_src_node,
  input  logic [TID_WIDTH-1:0]    req_tid,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [7:0]              req_len,
  input  logic [2:0]              req_size,
  input  logic [1:0]              req_burst,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic [ID_WIDTH-1:0]     axi_ax_id,
  output logic [ADDR_WIDTH-1:0]   axi_ax_addr,
  output logic [7:0]              axi_ax_len,
  output logic [2:0]              axi_ax_size,
  output logic [1:0]              axi_ax_burst,
  output logic                    axi_awvalid,
  output logic                    axi_arvalid,
  input  logic                    axi_awready,
  input  logic                    axi_arready,
  output logic                    axi_wvalid,
  output logic                    axi_wlast,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_bvalid,
  input  logic                    axi_bready,
  output logic [NODE_WIDTH-1:0]   wtag_node,
  output logic [TID_WIDTH-1:0]    wtag_tid,
  output logic                    wtag_empty,
  output logic                    routing_error,
  output logic                    b_unexpected
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = NODE_WIDTH + TID_WIDTH;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // AXI ID selection is fixed at elaboration time
  logic [ID_WIDTH-1:0] id_new;
  generate
    if (ID_MODE == 0) begin : g_id_src_tid
      assign id_new = ID_WIDTH'({req_src_node, req_tid});
    end else if (ID_MODE == 1) begin : g_id_src
      assign id_new = ID_WIDTH'(req_src_node);
    end else begin : g_id_zero
      assign id_new = '0;
    end
  endgenerate

  logic                  ax_full_q,  ax_full_d;
  logic                  ax_write_q, ax_write_d;
  logic [ID_WIDTH-1:0]   ax_id_q,    ax_id_d;
  logic [ADDR_WIDTH-1:0] ax_addr_q,  ax_addr_d;
  logic [7:0]            ax_len_q,   ax_len_d;
  logic [2:0]            ax_size_q,  ax_size_d;
  logic [1:0]            ax_burst_q, ax_burst_d;

  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]      lenq_wr_q,  lenq_wr_d;
  logic [PTR_W-1:0]      lenq_rd_q,  lenq_rd_d;
  logic [CNT_W-1:0]      lenq_cnt_q, lenq_cnt_d;
  logic [PTR_W-1:0]      tagq_wr_q,  tagq_wr_d;
  logic [PTR_W-1:0]      tagq_rd_q,  tagq_rd_d;
  logic [CNT_W-1:0]      tagq_cnt_q, tagq_cnt_d;
  logic                  routing_error_q, routing_error_d;
  logic                  b_unexpected_q,  b_unexpected_d;

  logic [7:0]            lenq_mem_q [MAX_OUTSTANDING];
  logic [TAG_W-1:0]      tagq_mem_q [MAX_OUTSTANDING];

  logic ax_hs, ax_full_next, req_acc, wr_acc;
  logic lenq_nonempty, tagq_nonempty, w_hs, last_hs, b_hs, tag_pop;
  logic [7:0] lenq_head;

  assign lenq_nonempty = (lenq_cnt_q != '0);
  assign tagq_nonempty = (tagq_cnt_q != '0);
  assign lenq_head     = lenq_mem_q[lenq_rd_q];

  always_comb begin
    ax_hs        = ax_full_q & (ax_write_q ? axi_awready : axi_arready);
    ax_full_next = ax_full_q & ~ax_hs;
    // The tag-queue occupancy doubles as the outstanding-write count
    req_ready    = ~ax_full_next & (~req_write | (tagq_cnt_q < MAX_CNT));
    req_acc      = req_valid & req_ready;
    wr_acc       = req_acc & req_write;
    w_hs         = axi_wvalid & axi_wready;
    last_hs      = w_hs & axi_wlast;
    b_hs         = axi_bvalid & axi_bready;
    tag_pop      = b_hs & tagq_nonempty;
  end

  always_comb begin
    ax_full_d  = req_acc | ax_full_next;
    ax_write_d = ax_write_q;
    ax_id_d    = ax_id_q;
    ax_addr_d  = ax_addr_q;
    ax_len_d   = ax_len_q;
    ax_size_d  = ax_size_q;
    ax_burst_d = ax_burst_q;
    if (req_acc) begin
      ax_write_d = req_write;
      ax_id_d    = id_new;
      ax_addr_d  = req_addr;
      ax_len_d   = req_len;
      ax_size_d  = req_size;
      ax_burst_d = req_burst;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (last_hs) begin
      beat_cnt_d = '0;
    end else if (w_hs) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end

    lenq_wr_d  = wr_acc  ? lenq_wr_q + 1'b1 : lenq_wr_q;
    lenq_rd_d  = last_hs ? lenq_rd_q + 1'b1 : lenq_rd_q;
    lenq_cnt_d = lenq_cnt_q;
    if (wr_acc && !last_hs) begin
      lenq_cnt_d = lenq_cnt_q + 1'b1;
    end else if (!wr_acc && last_hs) begin
      lenq_cnt_d = lenq_cnt_q - 1'b1;
    end

    tagq_wr_d  = wr_acc  ? tagq_wr_q + 1'b1 : tagq_wr_q;
    tagq_rd_d  = tag_pop ? tagq_rd_q + 1'b1 : tagq_rd_q;
    tagq_cnt_d = tagq_cnt_q;
    if (wr_acc && !tag_pop) begin
      tagq_cnt_d = tagq_cnt_q + 1'b1;
    end else if (!wr_acc && tag_pop) begin
      tagq_cnt_d = tagq_cnt_q - 1'b1;
    end

    routing_error_d = routing_error_q |
                      (req_acc & (req_dst_node != NODE_WIDTH'(NODE_ID)));
    b_unexpected_d  = b_unexpected_q | (b_hs & ~tagq_nonempty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ax_full_q       <= 1'b0;
      ax_write_q      <= 1'b0;
      ax_id_q         <= '0;
      ax_addr_q       <= '0;
      ax_len_q        <= '0;
      ax_size_q       <= '0;
      ax_burst_q      <= '0;
      beat_cnt_q      <= '0;
      lenq_wr_q       <= '0;
      lenq_rd_q       <= '0;
      lenq_cnt_q      <= '0;
      tagq_wr_q       <= '0;
      tagq_rd_q       <= '0;
      tagq_cnt_q      <= '0;
      routing_error_q <= 1'b0;
      b_unexpected_q  <= 1'b0;
    end else begin
      ax_full_q       <= ax_full_d;
      ax_write_q      <= ax_write_d;
      ax_id_q         <= ax_id_d;
      ax_addr_q       <= ax_addr_d;
      ax_len_q        <= ax_len_d;
      ax_size_q       <= ax_size_d;
      ax_burst_q      <= ax_burst_d;
      beat_cnt_q      <= beat_cnt_d;
      lenq_wr_q       <= lenq_wr_d;
      lenq_rd_q       <= lenq_rd_d;
      lenq_cnt_q      <= lenq_cnt_d;
      tagq_wr_q       <= tagq_wr_d;
      tagq_rd_q       <= tagq_rd_d;
      tagq_cnt_q      <= tagq_cnt_d;
      routing_error_q <= routing_error_d;
      b_unexpected_q  <= b_unexpected_d;
    end
  end

  // Queue storage needs no reset: occupancy counters guard every read
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      lenq_mem_q[lenq_wr_q] <= req_len;
      tagq_mem_q[tagq_wr_q] <= {req_src_node, req_tid};
    end
  end

  assign axi_ax_id     = ax_id_q;
  assign axi_ax_addr   = ax_addr_q;
  assign axi_ax_len    = ax_len_q;
  assign axi_ax_size   = ax_size_q;
  assign axi_ax_burst  = ax_burst_q;
  assign axi_awvalid   = ax_full_q & ax_write_q;
  assign axi_arvalid   = ax_full_q & ~ax_write_q;

  assign axi_wvalid    = wd_valid & lenq_nonempty;
  assign wd_ready      = axi_wready & lenq_nonempty;
  assign axi_wlast     = lenq_nonempty & (beat_cnt_q == lenq_head);
  assign axi_wdata     = wd_data;
  assign axi_wstrb     = wd_strb;

  assign wtag_node     = tagq_mem_q[tagq_rd_q][TAG_W-1:TID_WIDTH];
  assign wtag_tid      = tagq_mem_q[tagq_rd_q][TID_WIDTH-1:0];
  assign wtag_empty    = ~tagq_nonempty;
  assign routing_error = routing_error_q;
  assign b_unexpected  = b_unexpected_q;

endmodule
`default_nettype wire

// File: tb/tb_munoc_slave_req_dispatcher.sv
`default_nettype none
// ============================================================================
// tb_munoc_slave_req_dispatcher : directed bench for the slave request dispatcher
// Revision : 1.0
// ============================================================================
module tb_munoc_slave_req_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_dst_node, req_src_node, req_tid;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic [7:0]  axi_ax_id;
  logic [31:0] axi_ax_addr;
  logic [7:0]  axi_ax_len;
  logic [2:0]  axi_ax_size;
  logic [1:0]  axi_ax_burst;
  logic        axi_awvalid, axi_arvalid, axi_awready, axi_arready;
  logic        axi_wvalid, axi_wlast, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [3:0]  wtag_node, wtag_tid;
  logic        wtag_empty, routing_error, b_unexpected;

  int errors = 0;
  int checks = 0;
  int hs_cnt;

  always #5 clk = ~clk;

  munoc_slave_req_dispatcher #(
    .NODE_ID(1), .NODE_WIDTH(4), .TID_WIDTH(4), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .ID_WIDTH(8), .ID_MODE(0), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_dst_node(req_dst_node), .req_src_node(req_src_node), .req_tid(req_tid),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .axi_ax_id(axi_ax_id), .axi_ax_addr(axi_ax_addr), .axi_ax_len(axi_ax_len),
    .axi_ax_size(axi_ax_size), .axi_ax_burst(axi_ax_burst),
    .axi_awvalid(axi_awvalid), .axi_arvalid(axi_arvalid),
    .axi_awready(axi_awready), .axi_arready(axi_arready),
    .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .wtag_node(wtag_node), .wtag_tid(wtag_tid), .wtag_empty(wtag_empty),
    .routing_error(routing_error), .b_unexpected(b_unexpected)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [3:0] dst, input logic [3:0] src,
                         input logic [3:0] tid, input logic [31:0] addr, input logic [7:0] len);
    req_valid    = 1'b1;
    req_write    = wr;
    req_dst_node = dst;
    req_src_node = src;
    req_tid      = tid;
    req_addr     = addr;
    req_len      = len;
    req_size     = 3'd2;
    req_burst    = 2'd1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_dst_node = 4'd1; req_src_node = 0; req_tid = 0;
    req_addr = 0; req_len = 0; req_size = 0; req_burst = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 4'hF;
    axi_awready = 0; axi_arready = 0; axi_wready = 0; axi_bvalid = 0; axi_bready = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_awvalid", axi_awvalid, 1'b0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_wtag_empty", wtag_empty, 1'b1);
    chk("rst_routing_error", routing_error, 1'b0);
    chk("rst_b_unexpected", b_unexpected, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);

    // Read held off by arready=0
    set_req(1'b0, 4'd1, 4'd2, 4'd5, 32'h100, 8'd3);
    #1;
    chk("rd_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("rd_arvalid", axi_arvalid, 1'b1);
    chk("rd_awvalid", axi_awvalid, 1'b0);
    chk("rd_ax_id", axi_ax_id, 8'h25);
    chk("rd_ax_len", axi_ax_len, 8'd3);
    chk("rd_ax_addr", axi_ax_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold_arvalid", axi_arvalid, 1'b1);
      chk("rd_hold_addr", axi_ax_addr, 32'h100);
      chk("rd_hold_id", axi_ax_id, 8'h25);
    end
    req_valid = 1'b1;
    #1;
    chk("rd_full_req_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    axi_arready = 1'b1;
    #1;
    chk("rd_drain_req_ready", req_ready, 1'b1);
    tick();
    axi_arready = 1'b0;
    chk("rd_arvalid_drop", axi_arvalid, 1'b0);

    // Write len 3 with toggling wready
    set_req(1'b1, 4'd1, 4'd2, 4'd5, 32'h200, 8'd3);
    tick();
    req_valid = 1'b0;
    chk("wr_awvalid", axi_awvalid, 1'b1);
    chk("wr_wtag_node", wtag_node, 4'd2);
    chk("wr_wtag_tid", wtag_tid, 4'd5);
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    chk("wr_awvalid_drop", axi_awvalid, 1'b0);
    hs_cnt = 0;
    wd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_wready = i[0];
      wd_data = 32'hA0 + 32'(i / 2);
      #1;
      chk("wr_wvalid", axi_wvalid, 1'b1);
      chk("wr_wdata", axi_wdata, 32'hA0 + 32'(i / 2));
      if (i[0]) begin
        chk("wr_wd_ready", wd_ready, 1'b1);
        chk("wr_wlast", axi_wlast, (i / 2) == 3);
      end
      if (axi_wvalid && axi_wready) hs_cnt++;
      tick();
    end
    chk("wr_hs_count", hs_cnt, 4);
    chk("wr_lenq_empty_wvalid", axi_wvalid, 1'b0);
    chk("wr_lenq_empty_wd_ready", wd_ready, 1'b0);
    chk("wr_wtag_node_after", wtag_node, 4'd2);
    wd_valid = 1'b0;
    axi_wready = 1'b0;
    axi_bvalid = 1'b1; axi_bready = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    chk("wr_b_pop_empty", wtag_empty, 1'b1);

    // Four outstanding writes saturate the tag queue
    axi_awready = 1'b1;
    axi_arready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      set_req(1'b1, 4'd1, 4'(k), 4'(k), 32'h400 + 32'(k), 8'd0);
      #1;
      chk("ost_req_ready", req_ready, 1'b1);
      tick();
    end
    set_req(1'b1, 4'd1, 4'd5, 4'd5, 32'h500, 8'd0);
    #1;
    chk("ost_fifth_write_blocked", req_ready, 1'b0);
    req_write = 1'b0;
    #1;
    chk("ost_read_allowed", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("ost_read_arvalid", axi_arvalid, 1'b1);
    chk("ost_head_node", wtag_node, 4'd1);
    wd_valid = 1'b1; axi_wready = 1'b1;
    #1;
    chk("ost_len0_wlast", axi_wlast, 1'b1);
    tick();
    wd_valid = 1'b0;
    axi_bvalid = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    set_req(1'b1, 4'd1, 4'd5, 4'd5, 32'h500, 8'd0);
    #1;
    chk("ost_write_after_b", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("ost_head_after_b", wtag_node, 4'd2);
    wd_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    wd_valid = 1'b0;
    axi_bvalid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    axi_bvalid = 1'b0;
    chk("ost_drained", wtag_empty, 1'b1);
    chk("ost_no_b_unexpected", b_unexpected, 1'b0);

    // Back-to-back reads at full rate
    for (int k = 0; k < 4; k++) begin
      set_req(1'b0, 4'd1, 4'd3, 4'(k), 32'h1000 + 32'(16 * k), 8'd1);
      #1;
      chk("b2b_req_ready", req_ready, 1'b1);
      tick();
      chk("b2b_arvalid", axi_arvalid, 1'b1);
      chk("b2b_addr", axi_ax_addr, 32'h1000 + 32'(16 * k));
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_arvalid_idle", axi_arvalid, 1'b0);

    // Misrouted request and unexpected B
    axi_arready = 1'b0;
    set_req(1'b0, 4'd3, 4'd2, 4'd1, 32'h300, 8'd0);
    tick();
    req_valid = 1'b0;
    chk("rte_flag", routing_error, 1'b1);
    chk("rte_forwarded", axi_arvalid, 1'b1);
    chk("rte_addr", axi_ax_addr, 32'h300);
    axi_arready = 1'b1;
    tick();
    set_req(1'b0, 4'd1, 4'd2, 4'd1, 32'h304, 8'd0);
    tick();
    req_valid = 1'b0;
    chk("rte_sticky", routing_error, 1'b1);
    axi_bvalid = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    chk("bunexp_flag", b_unexpected, 1'b1);
    chk("bunexp_queue_empty", wtag_empty, 1'b1);

    // Reset in the middle of a len-7 burst
    set_req(1'b1, 4'd1, 4'd6, 4'd3, 32'h800, 8'd7);
    tick();
    req_valid = 1'b0;
    wd_valid = 1'b1; axi_wready = 1'b1;
    #1;
    chk("mid_beat0_wlast", axi_wlast, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_wvalid", axi_wvalid, 1'b0);
    chk("mid_rst_awvalid", axi_awvalid, 1'b0);
    chk("mid_rst_wtag_empty", wtag_empty, 1'b1);
    chk("mid_rst_routing_error", routing_error, 1'b0);
    chk("mid_rst_b_unexpected", b_unexpected, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
